// File: rtl/ram_arb_pkg.sv
// Shared types and constants for the two-port RAM16K arbiter.
package ram_arb_pkg;
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    localparam int ADDR_W_DEF = 14;
    localparam int DATA_W_DEF = 16;

    localparam logic SIDE0 = 1'b0;
    localparam logic SIDE1 = 1'b1;
endpackage

// File: rtl/ram_arb_pick.sv
// Combinational winner select: owner keeps the RAM until it drops req or
// its hold budget runs out while the other side waits.
import ram_arb_pkg::*;

module ram_arb_pick (
    input  arb_state_t state,
    input  logic       rr,
    input  logic       req0,
    input  logic       req1,
    input  logic       hold_max,
    output logic       gnt0,
    output logic       gnt1
);
    logic idle0;
    logic idle1;

    assign idle0 = req0 & (~req1 | (rr == SIDE0));
    assign idle1 = req1 & (~req0 | (rr == SIDE1));

    always_comb begin
        gnt0 = idle0;
        gnt1 = idle1;
        case (state)
            OWN0: if (req0 && (!req1 || !hold_max)) begin
                gnt0 = 1'b1;
                gnt1 = 1'b0;
            end
            OWN1: if (req1 && (!req0 || !hold_max)) begin
                gnt0 = 1'b0;
                gnt1 = 1'b1;
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/ram16k_arbiter.sv
// Round-robin arbiter sharing one RAM16K between two requesters, with
// bounded lock ownership and registered read return.
//
// state | meaning
// IDLE  | no owner, round-robin decides between simultaneous requests
// OWN0  | requester 0 holds the RAM after a locked grant
// OWN1  | requester 1 holds the RAM after a locked grant
import ram_arb_pkg::*;

module ram16k_arbiter #(
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int DATA_W   = DATA_W_DEF,
    parameter int MAX_HOLD = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic              lock0,
    input  logic              lock1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] ram_in,
    output logic              ram_load,
    output logic [ADDR_W-1:0] ram_address,
    input  logic [DATA_W-1:0] ram_out
);
    localparam int                HOLD_W   = $clog2(MAX_HOLD + 1);
    localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(MAX_HOLD);

    arb_state_t        state;
    logic              rr;
    logic [HOLD_W-1:0] hold_cnt;
    logic [HOLD_W-1:0] hold_inc;
    logic              pick0;
    logic              pick1;
    logic              keep;

    ram_arb_pick u_pick (
        .state    (state),
        .rr       (rr),
        .req0     (req0),
        .req1     (req1),
        .hold_max (hold_cnt == HOLD_LIM),
        .gnt0     (pick0),
        .gnt1     (pick1)
    );

    // Grants are gated by reset so nothing reaches the RAM while held in reset.
    assign gnt0 = pick0 & rst_n;
    assign gnt1 = pick1 & rst_n;

    assign ram_load    = (gnt0 & we0) | (gnt1 & we1);
    assign ram_address = gnt0 ? addr0  : (gnt1 ? addr1  : '0);
    assign ram_in      = gnt0 ? wdata0 : (gnt1 ? wdata1 : '0);

    assign keep     = ((state == OWN0) & gnt0) | ((state == OWN1) & gnt1);
    assign hold_inc = (hold_cnt == HOLD_LIM) ? HOLD_LIM : hold_cnt + HOLD_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            rr       <= SIDE0;
            hold_cnt <= '0;
            rvalid0  <= 1'b0;
            rvalid1  <= 1'b0;
            rdata0   <= '0;
            rdata1   <= '0;
        end else begin
            rvalid0 <= gnt0 & ~we0;
            rvalid1 <= gnt1 & ~we1;
            if (gnt0 && !we0) rdata0 <= ram_out;
            if (gnt1 && !we1) rdata1 <= ram_out;

            // rr only advances on grants decided by the round-robin rule.
            if ((gnt0 || gnt1) && !keep)
                rr <= gnt0 ? SIDE1 : SIDE0;

            if (gnt0) begin
                if (lock0) begin
                    state    <= OWN0;
                    hold_cnt <= (state == OWN0) ? hold_inc : HOLD_W'(1);
                end else begin
                    state    <= IDLE;
                    hold_cnt <= '0;
                end
            end else if (gnt1) begin
                if (lock1) begin
                    state    <= OWN1;
                    hold_cnt <= (state == OWN1) ? hold_inc : HOLD_W'(1);
                end else begin
                    state    <= IDLE;
                    hold_cnt <= '0;
                end
            end else begin
                state    <= IDLE;
                hold_cnt <= '0;
            end
        end
    end
endmodule

// File: tb/tb_ram16k_arbiter.sv
// Directed bench for ram16k_arbiter with a behavioural RAM16K attached.
module tb_ram16k_arbiter;
    logic        clk;
    logic        rst_n;
    logic        req0, req1, we0, we1, lock0, lock1;
    logic [13:0] addr0, addr1;
    logic [15:0] wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1;
    logic [15:0] rdata0, rdata1;
    logic [15:0] ram_in;
    logic        ram_load;
    logic [13:0] ram_address;
    logic [15:0] ram_out;

    logic [15:0] mem [0:16383];

    int n_cmp = 0;
    int n_err = 0;

    ram16k_arbiter dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req0        (req0),
        .req1        (req1),
        .we0         (we0),
        .we1         (we1),
        .lock0       (lock0),
        .lock1       (lock1),
        .addr0       (addr0),
        .addr1       (addr1),
        .wdata0      (wdata0),
        .wdata1      (wdata1),
        .gnt0        (gnt0),
        .gnt1        (gnt1),
        .rvalid0     (rvalid0),
        .rvalid1     (rvalid1),
        .rdata0      (rdata0),
        .rdata1      (rdata1),
        .ram_in      (ram_in),
        .ram_load    (ram_load),
        .ram_address (ram_address),
        .ram_out     (ram_out)
    );

    assign ram_out = mem[ram_address];
    always @(posedge clk) if (ram_load) mem[ram_address] <= ram_in;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive0(input logic r, input logic w, input logic l,
                          input logic [13:0] a, input logic [15:0] d);
        req0 = r; we0 = w; lock0 = l; addr0 = a; wdata0 = d;
    endtask

    task automatic drive1(input logic r, input logic w, input logic l,
                          input logic [13:0] a, input logic [15:0] d);
        req1 = r; we1 = w; lock1 = l; addr1 = a; wdata1 = d;
    endtask

    initial begin
        logic e1;
        rst_n = 1'b0;
        drive0(1, 1, 0, 14'h0005, 16'hBEEF);
        drive1(1, 1, 0, 14'h0007, 16'h0001);
        #2;
        chk("rst_gnt0", gnt0, 0);
        chk("rst_gnt1", gnt1, 0);
        chk("rst_load", ram_load, 0);
        chk("rst_addr", ram_address, 0);
        chk("rst_in", ram_in, 0);
        chk("rst_rvalid0", rvalid0, 0);
        chk("rst_rdata0", rdata0, 0);
        chk("rst_rdata1", rdata1, 0);

        // write then read back on side 0
        @(negedge clk); rst_n = 1'b1; drive1(0, 0, 0, 0, 0); #1;
        chk("t1_wr_gnt0", gnt0, 1);
        chk("t1_wr_load", ram_load, 1);
        chk("t1_wr_addr", ram_address, 14'h0005);
        chk("t1_wr_in", ram_in, 16'hBEEF);
        @(negedge clk); drive0(1, 0, 0, 14'h0005, 0); #1;
        chk("t1_rd_gnt0", gnt0, 1);
        chk("t1_rd_load", ram_load, 0);
        chk("t1_rd_rvalid0", rvalid0, 0);
        @(negedge clk); drive0(0, 0, 0, 0, 0); #1;
        chk("t1_rvalid0", rvalid0, 1);
        chk("t1_rdata0", rdata0, 16'hBEEF);
        chk("t1_idle_gnt0", gnt0, 0);
        chk("t1_idle_addr", ram_address, 0);

        // side 1 writes 0x3FFF while side 0 waits to read it (rr points at 1)
        @(negedge clk);
        drive0(1, 0, 0, 14'h3FFF, 0);
        drive1(1, 1, 0, 14'h3FFF, 16'h1234);
        #1;
        chk("t3_gnt1", gnt1, 1);
        chk("t3_gnt0", gnt0, 0);
        chk("t3_in", ram_in, 16'h1234);
        chk("t3_rvalid0", rvalid0, 0);
        @(negedge clk); drive1(0, 0, 0, 0, 0); #1;
        chk("t3_gnt0_next", gnt0, 1);
        chk("t3_addr", ram_address, 14'h3FFF);
        @(negedge clk); drive0(0, 0, 0, 0, 0); #1;
        chk("t3_rvalid0", rvalid0, 1);
        chk("t3_rdata0", rdata0, 16'h1234);

        // both reading without lock: rr starts at 1, so grants go 1,0,1,0,1,0
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            if (i == 0) begin
                drive0(1, 0, 0, 14'h0005, 0);
                drive1(1, 0, 0, 14'h3FFF, 0);
            end
            #1;
            e1 = (i % 2 == 0);
            chk("t2_gnt1", gnt1, e1);
            chk("t2_gnt0", gnt0, !e1);
            chk("t2_both", gnt0 & gnt1, 0);
            if (i > 0) begin
                chk("t2_rvalid1", rvalid1, !e1);
                chk("t2_rvalid0", rvalid0, e1);
            end
            if (i == 1) chk("t2_rdata1", rdata1, 16'h1234);
            if (i == 2) chk("t2_rdata0", rdata0, 16'hBEEF);
        end

        // locked burst on side 0; side 1 forces handover after 8 grants,
        // then again once hold_cnt has saturated
        for (int i = 0; i < 21; i++) begin
            @(negedge clk);
            drive0(1, 0, 1, 14'h0005, 0);
            drive1(((i >= 2) && (i <= 8)) || (i == 20), 0, 0, 14'h3FFF, 0);
            #1;
            e1 = (i == 8) || (i == 20);
            chk("t4_gnt1", gnt1, e1);
            chk("t4_gnt0", gnt0, !e1);
            if (i == 9) begin
                chk("t4_rvalid1", rvalid1, 1);
                chk("t4_rvalid0", rvalid0, 0);
            end
        end

        // reset in the middle of a locked write burst
        @(negedge clk); drive0(1, 1, 1, 14'h0022, 16'h7777); drive1(0, 0, 0, 0, 0); #1;
        chk("t5_wr_gnt0", gnt0, 1);
        chk("t5_wr_load", ram_load, 1);
        @(negedge clk); drive0(1, 0, 1, 14'h0005, 0); #1;
        chk("t5_rd_gnt0", gnt0, 1);
        @(negedge clk); drive0(1, 1, 1, 14'h0022, 16'h3333); drive1(1, 0, 0, 14'h0005, 0); #1;
        chk("t5_own_gnt0", gnt0, 1);
        chk("t5_own_load", ram_load, 1);
        chk("t5_rvalid0", rvalid0, 1);
        chk("t5_rdata0", rdata0, 16'hBEEF);
        rst_n = 1'b0; #1;
        chk("t5_rst_gnt0", gnt0, 0);
        chk("t5_rst_gnt1", gnt1, 0);
        chk("t5_rst_load", ram_load, 0);
        chk("t5_rst_addr", ram_address, 0);
        chk("t5_rst_rvalid0", rvalid0, 0);
        chk("t5_rst_rdata0", rdata0, 0);
        @(negedge clk); rst_n = 1'b1; drive0(1, 0, 0, 14'h0022, 0); #1;
        chk("t5_post_gnt0", gnt0, 1);
        chk("t5_post_gnt1", gnt1, 0);
        @(negedge clk); drive0(0, 0, 0, 0, 0); #1;
        chk("t5_nowrite_rvalid0", rvalid0, 1);
        chk("t5_nowrite_rdata0", rdata0, 16'h7777);
        chk("t5_gnt1", gnt1, 1);

        // single read then idle: rvalid pulses once, rdata holds
        @(negedge clk); drive1(1, 1, 0, 14'h0010, 16'h5A5A); #1;
        chk("t6_wr_gnt1", gnt1, 1);
        chk("t6_rvalid1", rvalid1, 1);
        chk("t6_rdata1", rdata1, 16'hBEEF);
        @(negedge clk); drive1(0, 0, 0, 0, 0); drive0(1, 0, 0, 14'h0010, 0); #1;
        chk("t6_rd_gnt0", gnt0, 1);
        chk("t6_rvalid1_low", rvalid1, 0);
        @(negedge clk); drive0(0, 0, 0, 0, 0); #1;
        chk("t6_rvalid0", rvalid0, 1);
        chk("t6_rdata0", rdata0, 16'h5A5A);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk); #1;
            chk("t6_hold_rvalid0", rvalid0, 0);
            chk("t6_hold_rdata0", rdata0, 16'h5A5A);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
